// File: rtl/oflow_fsm_read_pkg.sv
// oflow_fsm_read_pkg: shared widths, history limit, state enum and frame search helper for the oflow read FSM.
package oflow_fsm_read_pkg;
  localparam int TOTAL_FRAME_NUM_WIDTH = 8;
  localparam int NUM_OF_HISTORY_FRAMES_WIDTH = 3;
  localparam int ADDR_WIDTH = 8;
  localparam int OFFSET_WIDTH = 8;
  localparam int MAX_HISTORY = 5;
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
  typedef logic [TOTAL_FRAME_NUM_WIDTH-1:0] frame_t;
  typedef logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] idx_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [OFFSET_WIDTH-1:0] off_t;
  typedef logic [OFFSET_WIDTH:0] wide_t;
  typedef logic [MAX_HISTORY-1:0][ADDR_WIDTH-1:0] ptrs_t;
  // Lowest non-empty frame index in [from, h); MAX_HISTORY when none is left.
  function automatic idx_t next_frame(ptrs_t ptrs, idx_t h, idx_t from);
    idx_t r;
    r = idx_t'(MAX_HISTORY);
    for (int j = MAX_HISTORY - 1; j >= 0; j--)
      if (idx_t'(j) >= from && idx_t'(j) < h && ptrs[j] != '0) r = idx_t'(j);
    return r;
  endfunction
endpackage

// File: rtl/oflow_fsm_read_if.sv
// oflow_fsm_read_if: start/ready handshake, sweep configuration and line outputs of the oflow read FSM.
interface oflow_fsm_read_if;
  import oflow_fsm_read_pkg::*;
  frame_t frame_num;
  idx_t num_of_history_frames;
  ptrs_t end_pointers;
  logic start_read;
  logic similarity_metric_flag_ready_to_read_new_line;
  logic done_read;
  frame_t frame_to_read;
  off_t offset_0;
  off_t offset_1;
  modport master (
    output frame_num, num_of_history_frames, end_pointers, start_read,
    output similarity_metric_flag_ready_to_read_new_line,
    input done_read, frame_to_read, offset_0, offset_1
  );
  modport slave (
    input frame_num, num_of_history_frames, end_pointers, start_read,
    input similarity_metric_flag_ready_to_read_new_line,
    output done_read, frame_to_read, offset_0, offset_1
  );
endinterface

// File: rtl/oflow_fsm_read.sv
// oflow_fsm_read: walks latched history frames newest-first, two bbox offsets per line, advancing on ready.
// Define OFLOW_FSM_READ_HISTORY_CLAMP_EN to stop the sweep at frame 0 instead of wrapping frame numbers.
module oflow_fsm_read
  import oflow_fsm_read_pkg::*;
(
  input logic clk,
  input logic reset_N,
  oflow_fsm_read_if.slave bus
);
  state_t state;
  logic load, done, more;
  frame_t fn, ftr;
  idx_t h, h_lim, h_in, k, cand_k;
  ptrs_t ep;
  off_t off0, off1;
  wide_t nxt_o, cur_n;
  assign h_lim = (bus.num_of_history_frames > idx_t'(MAX_HISTORY)) ? idx_t'(MAX_HISTORY) : bus.num_of_history_frames;
`ifdef OFLOW_FSM_READ_HISTORY_CLAMP_EN
  assign h_in = (bus.frame_num < frame_t'(h_lim)) ? idx_t'(bus.frame_num) : h_lim;
`else
  assign h_in = h_lim;
`endif
  assign cur_n = wide_t'(ep[k]);
  assign nxt_o = wide_t'(off0) + wide_t'(2);
  assign more = nxt_o < cur_n;
  // The load cycle after start searches from frame 0; afterwards from the frame after the current one.
  assign cand_k = next_frame(ep, h, load ? idx_t'(0) : k + idx_t'(1));
  assign bus.done_read = done;
  assign bus.frame_to_read = ftr;
  assign bus.offset_0 = off0;
  assign bus.offset_1 = off1;
  always_ff @(posedge clk or posedge reset_N)
    if (reset_N) begin
      state <= IDLE;
      load <= 1'b0;
      done <= 1'b0;
      fn <= '0;
      h <= '0;
      k <= '0;
      ep <= '0;
      ftr <= '0;
      off0 <= '0;
      off1 <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_read) begin
          state <= READ;
          load <= 1'b1;
          fn <= bus.frame_num;
          h <= h_in;
          ep <= bus.end_pointers;
        end
        READ: if (load || bus.similarity_metric_flag_ready_to_read_new_line) begin
          load <= 1'b0;
          if (!load && more) begin
            off0 <= off_t'(nxt_o);
            off1 <= (nxt_o + wide_t'(1) < cur_n) ? off_t'(nxt_o + wide_t'(1)) : off_t'(nxt_o);
          end else if (cand_k != idx_t'(MAX_HISTORY)) begin
            k <= cand_k;
            ftr <= fn - frame_t'(1) - frame_t'(cand_k);
            off0 <= '0;
            off1 <= off_t'(ep[cand_k] > addr_t'(1));
          end else begin
            state <= DONE;
            done <= 1'b1;
            ftr <= '0;
            off0 <= '0;
            off1 <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_oflow_fsm_read.sv
// tb_oflow_fsm_read: directed sweeps with hand-computed line tables for oflow_fsm_read.
module tb_oflow_fsm_read;
  import oflow_fsm_read_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int qf[$], q0[$], q1[$];
  oflow_fsm_read_if bus();
  oflow_fsm_read dut (.clk(clk), .reset_N(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input int d, input int f, input int a, input int b);
    check({tag, "_done"}, 32'(bus.done_read), d);
    check({tag, "_frame"}, 32'(bus.frame_to_read), f);
    check({tag, "_off0"}, 32'(bus.offset_0), a);
    check({tag, "_off1"}, 32'(bus.offset_1), b);
  endtask
  task automatic setup(input int fn, input int h, input int e0, input int e1, input int e2, input int e3, input int e4);
    bus.frame_num = frame_t'(fn);
    bus.num_of_history_frames = idx_t'(h);
    bus.end_pointers = {addr_t'(e4), addr_t'(e3), addr_t'(e2), addr_t'(e1), addr_t'(e0)};
    qf.delete();
    q0.delete();
    q1.delete();
  endtask
  task automatic add(input int f, input int a, input int b);
    qf.push_back(f);
    q0.push_back(a);
    q1.push_back(b);
  endtask
  task automatic pulse_ready();
    bus.similarity_metric_flag_ready_to_read_new_line = 1'b1;
    @(negedge clk);
    bus.similarity_metric_flag_ready_to_read_new_line = 1'b0;
  endtask
  task automatic sweep(input string name, input int extra);
    @(negedge clk);
    bus.start_read = 1'b1;
    @(negedge clk);
    bus.start_read = 1'b0;
    // Scramble inputs: the sweep must run from the values latched at start.
    bus.frame_num = 8'd200;
    bus.num_of_history_frames = 3'd1;
    bus.end_pointers = '0;
    @(negedge clk);
    for (int i = 0; i < qf.size(); i++) begin
      chk_out($sformatf("%s_l%0d", name, i), 0, qf[i], q0[i], q1[i]);
      bus.start_read = (i == 1);
      @(negedge clk);
      bus.start_read = 1'b0;
      repeat (2) @(negedge clk);
      chk_out($sformatf("%s_hold%0d", name, i), 0, qf[i], q0[i], q1[i]);
      pulse_ready();
    end
    chk_out({name, "_done"}, 1, 0, 0, 0);
    @(negedge clk);
    chk_out({name, "_idle"}, 0, 0, 0, 0);
    for (int e = 0; e < extra; e++) begin
      pulse_ready();
      chk_out($sformatf("%s_extra%0d", name, e), 0, 0, 0, 0);
    end
  endtask
  initial begin
    bus.start_read = 1'b0;
    bus.similarity_metric_flag_ready_to_read_new_line = 1'b0;
    setup(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    setup(12, 3, 9, 3, 5, 0, 0);
    add(11, 0, 1); add(11, 2, 3); add(11, 4, 5); add(11, 6, 7); add(11, 8, 8);
    add(10, 0, 1); add(10, 2, 2);
    add(9, 0, 1); add(9, 2, 3); add(9, 4, 4);
    sweep("basic", 0);
    setup(12, 3, 9, 3, 5, 0, 0);
    add(11, 0, 1); add(11, 2, 3); add(11, 4, 5); add(11, 6, 7); add(11, 8, 8);
    add(10, 0, 1); add(10, 2, 2);
    add(9, 0, 1); add(9, 2, 3); add(9, 4, 4);
    sweep("extra", 10);
    setup(12, 3, 0, 4, 0, 0, 0);
    add(10, 0, 1); add(10, 2, 3);
    sweep("skip", 0);
    setup(12, 0, 9, 3, 5, 1, 1);
    sweep("h0", 0);
    setup(12, 3, 0, 0, 0, 7, 7);
    sweep("empty", 0);
    setup(12, 7, 1, 1, 1, 1, 1);
    add(11, 0, 0); add(10, 0, 0); add(9, 0, 0); add(8, 0, 0); add(7, 0, 0);
    sweep("hmax", 0);
    setup(1, 3, 2, 2, 2, 2, 2);
    add(0, 0, 1);
`ifndef OFLOW_FSM_READ_HISTORY_CLAMP_EN
    add(255, 0, 1); add(254, 0, 1);
`endif
    sweep("wrap", 0);
    setup(12, 3, 9, 3, 5, 0, 0);
    @(negedge clk);
    bus.start_read = 1'b1;
    @(negedge clk);
    bus.start_read = 1'b0;
    @(negedge clk);
    chk_out("mid_l0", 0, 11, 0, 1);
    pulse_ready();
    chk_out("mid_l1", 0, 11, 2, 3);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    setup(12, 3, 9, 3, 5, 0, 0);
    add(11, 0, 1); add(11, 2, 3); add(11, 4, 5); add(11, 6, 7); add(11, 8, 8);
    add(10, 0, 1); add(10, 2, 2);
    add(9, 0, 1); add(9, 2, 3); add(9, 4, 4);
    sweep("restart", 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
